wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
- Commit-trace capture stage downstream of the pipelined MIPS top level.
- Consumes the writeback-side signals the processor exports (PC, write data, destination register, register-write strobe, stall) and records each architectural register write into a show-ahead FIFO.
- Entries are drained through a valid/ready port by the bench checker or a debug UART.
- Gives self-checking benches and hardware debug an exact, ordered list of retired register writes, independent of pipeline timing.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- PTR_W, 4, pointer width; equals log2(DEPTH).
- CNT_W, 32, width of the commit and drop counters.

Ports:
- Clock  in  1  rising-edge clock, shared with the processor.
- Reset  in  1  asynchronous, active-low reset.
- CaptureEn  in  1  capture enable; 0 ignores all writeback activity.
- Flush  in  1  synchronous clear of FIFO contents, flags and counters.
- ProgramCounter  in  32  PC of the instruction in writeback.
- WriteData  in  32  value being written to the register file.
- RegWrite  in  1  register-file write strobe.
- rDestSelected  in  5  destination register number.
- Stall  in  1  pipeline stall indicator.
- TraceValid  out  1  head entry is available.
- TraceReady  in  1  consumer accepts the head entry.
- TracePC  out  32  head entry PC.
- TraceDest  out  5  head entry destination register.
- TraceData  out  32  head entry data.
- Count  out  PTR_W+1  current occupancy, 0..DEPTH.
- Full  out  1  occupancy equals DEPTH.
- Overflow  out  1  sticky; set when a commit is dropped.
- CommitCount  out  CNT_W  total qualified commits seen, stored or dropped.
- DropCount  out  CNT_W  commits dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, Reset=0):
  - Pointers, Count, Overflow, CommitCount and DropCount are 0.
  - TraceValid=0 and Full=0.
  - TracePC, TraceDest and TraceData are 0. Storage contents are don't-care.
- Qualified commit, sampled at the rising edge: CaptureEn=1, RegWrite=1, Stall=0 and rDestSelected!=0. Writes to $zero are never recorded.
- Push: a qualified commit writes {ProgramCounter, rDestSelected, WriteData} at the write pointer and increments the write pointer modulo DEPTH.
- Pop: TraceValid=1 and TraceReady=1 at the edge increments the read pointer modulo DEPTH.
- Show-ahead output: TraceValid = (Count!=0). Trace* outputs reflect the head entry combinationally from storage. When Count=0, Trace* outputs are forced to 0.
- Latency: a commit sampled at edge N gives TraceValid=1 after edge N when the FIFO was empty, i.e. 1 cycle.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full, no pop that cycle: a qualified commit is dropped. DropCount increments, Overflow is set, contents are unchanged.
- Full, pop in the same cycle: push is permitted, Count stays at DEPTH, nothing is dropped.
- Empty with TraceReady=1: no effect and no pointer movement.
- CommitCount increments on every qualified commit, whether stored or dropped. Both counters wrap modulo 2^CNT_W.
- Overflow clears only on Reset or Flush.
- Flush=1 at an edge: pointers, Count, flags and counters clear. Flush has priority over any same-cycle push or pop; that commit is neither stored nor counted.
- Reset mid-operation: all state clears immediately and asynchronously. Capture resumes on the first edge after Reset returns high.
- Equivalent states: no internal state machine beyond EMPTY / PARTIAL / FULL, which is derived from Count.

Optional Feature:
- WB_TRACE_DEDUP_EN defined:
  - A qualified commit whose {PC, dest, data} equals the most recently qualified commit is suppressed. It is not stored and not counted.
  - This covers writeback signals held across a stall release.
  - The last-commit register clears on Reset and Flush, and is updated even when the FIFO is full.
- Not defined: every qualified commit is handled as described under Behaviour, with no comparison logic and no last-commit register.

Test Plan:
- Reset=0 then 1, no stimulus -> TraceValid=0, Count=0, Overflow=0, CommitCount=0, all Trace* outputs 0.
- Single commit PC=0x00000010, dest=2, data=0x0000002A, TraceReady=0 -> next cycle TraceValid=1, TracePC=0x10, TraceDest=2, TraceData=0x2A, Count=1. Asserting TraceReady for one cycle -> Count=0.
- Commits to dest=0, with Stall=1, and with CaptureEn=0 -> Count remains 0 and CommitCount remains 0.
- 18 back-to-back commits with TraceReady=0 and DEPTH=16 -> Full=1, Count=16, DropCount=2, CommitCount=18, Overflow=1. Draining returns the first 16 entries in order.
- Full FIFO with a simultaneous commit and TraceReady=1 -> Count stays 16, DropCount unchanged, the new entry appears last on drain.
- Same commit presented on two consecutive unstalled cycles -> 2 entries without WB_TRACE_DEDUP_EN, 1 entry with it. Then Flush=1 -> Count=0, Overflow=0, CommitCount=0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - show-ahead FIFO of retired register writes with commit/drop counters
// Optional WB_TRACE_DEDUP_EN suppresses a commit identical to the previous qualified one.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CaptureEn,
  input  logic             Flush,
  input  logic [31:0]      ProgramCounter,
  input  logic [31:0]      WriteData,
  input  logic             RegWrite,
  input  logic [4:0]       rDestSelected,
  input  logic             Stall,
  output logic             TraceValid,
  input  logic             TraceReady,
  output logic [31:0]      TracePC,
  output logic [4:0]       TraceDest,
  output logic [31:0]      TraceData,
  output logic [PTR_W:0]   Count,
  output logic             Full,
  output logic             Overflow,
  output logic [CNT_W-1:0] CommitCount,
  output logic [CNT_W-1:0] DropCount
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             qualified;
  logic             commit;
  logic             push;
  logic             pop;
  logic             drop;

  assign in_entry  = '{pc: ProgramCounter, dest: rDestSelected, data: WriteData};
  assign qualified = CaptureEn && RegWrite && !Stall && (rDestSelected != 5'd0);

`ifdef WB_TRACE_DEDUP_EN
  entry_t last_entry;
  logic   last_valid;

  // A writeback held across a stall release shows up twice; only the first counts.
  assign commit = qualified && !(last_valid && (last_entry == in_entry));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_valid <= 1'b0;
      last_entry <= '0;
    end else if (Flush) begin
      last_valid <= 1'b0;
      last_entry <= '0;
    end else if (qualified) begin
      last_valid <= 1'b1;
      last_entry <= in_entry;
    end
  end
`else
  assign commit = qualified;
`endif

  assign TraceValid = (Count != '0);
  assign Full       = (Count == FULL_COUNT);
  assign pop        = TraceValid && TraceReady;
  // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
  assign push       = commit && (!Full || pop);
  assign drop       = commit && Full && !pop;

  assign head      = mem[rd_ptr];
  assign TracePC   = TraceValid ? head.pc   : 32'd0;
  assign TraceDest = TraceValid ? head.dest : 5'd0;
  assign TraceData = TraceValid ? head.data : 32'd0;

  always_ff @(posedge Clock) begin
    if (push && !Flush) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Count       <= '0;
      Overflow    <= 1'b0;
      CommitCount <= '0;
      DropCount   <= '0;
    end else if (Flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Count       <= '0;
      Overflow    <= 1'b0;
      CommitCount <= '0;
      DropCount   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        Count <= Count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        Count <= Count - (PTR_W+1)'(1);
      end
      if (commit) begin
        CommitCount <= CommitCount + CNT_W'(1);
      end
      if (drop) begin
        DropCount <= DropCount + CNT_W'(1);
        Overflow  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - table-driven and scoreboard checks of wb_trace_buffer
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int CNT_W = 32;
`ifdef WB_TRACE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             CaptureEn = 1'b0;
  logic             Flush = 1'b0;
  logic [31:0]      ProgramCounter = '0;
  logic [31:0]      WriteData = '0;
  logic             RegWrite = 1'b0;
  logic [4:0]       rDestSelected = '0;
  logic             Stall = 1'b0;
  logic             TraceValid;
  logic             TraceReady = 1'b0;
  logic [31:0]      TracePC;
  logic [4:0]       TraceDest;
  logic [31:0]      TraceData;
  logic [PTR_W:0]   Count;
  logic             Full;
  logic             Overflow;
  logic [CNT_W-1:0] CommitCount;
  logic [CNT_W-1:0] DropCount;

  wb_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .CaptureEn(CaptureEn), .Flush(Flush),
    .ProgramCounter(ProgramCounter), .WriteData(WriteData), .RegWrite(RegWrite),
    .rDestSelected(rDestSelected), .Stall(Stall), .TraceValid(TraceValid),
    .TraceReady(TraceReady), .TracePC(TracePC), .TraceDest(TraceDest),
    .TraceData(TraceData), .Count(Count), .Full(Full), .Overflow(Overflow),
    .CommitCount(CommitCount), .DropCount(DropCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic        cap;
    logic        rw;
    logic        stl;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] data;
    logic        stored;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[7];
  int     n_cmp = 0;
  int     n_err = 0;
  int     exp_cnt;
  int     exp_commits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic cap, input logic rw, input logic stl, input logic [4:0] dest,
                       input logic [31:0] pc, input logic [31:0] data, input logic rdy,
                       input logic fl);
    CaptureEn = cap; RegWrite = rw; Stall = stl; rDestSelected = dest;
    ProgramCounter = pc; WriteData = data; TraceReady = rdy; Flush = fl;
    @(posedge Clock);
    #1;
    CaptureEn = 1'b0; RegWrite = 1'b0; Stall = 1'b0; rDestSelected = '0;
    ProgramCounter = '0; WriteData = '0; TraceReady = 1'b0; Flush = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] data);
    cycle(1'b1, 1'b1, 1'b0, dest, pc, data, 1'b0, 1'b0);
  endtask

  task automatic chk_head(input string tag);
    entry_t e;
    if (sb.size() == 0) begin
      chk({tag, "_valid"}, 32'(TraceValid), 32'd0);
    end else begin
      e = sb[0];
      chk({tag, "_valid"}, 32'(TraceValid), 32'd1);
      chk({tag, "_pc"}, TracePC, e.pc);
      chk({tag, "_dest"}, 32'(TraceDest), 32'(e.dest));
      chk({tag, "_data"}, TraceData, e.data);
    end
  endtask

  // Pops one entry per cycle; the loop bound protects against a FIFO that never empties.
  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) begin
      chk_head(tag);
      void'(sb.pop_front());
      cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    chk({tag, "_count_empty"}, 32'(Count), 32'd0);
    chk({tag, "_valid_empty"}, 32'(TraceValid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd2,  32'h0000_0010, 32'h0000_002A, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0014, 32'h0000_0055, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 5'd3,  32'h0000_0018, 32'h0000_0066, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd4,  32'h0000_001C, 32'h0000_0077, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd6,  32'h0000_0020, 32'h0000_0088, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd31, 32'h0000_0024, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'h0000_0028, 32'h0000_1234, 1'b1};

    #12;
    chk("rst_async_count", 32'(Count), 32'd0);
    chk("rst_async_valid", 32'(TraceValid), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    chk("rst_valid", 32'(TraceValid), 32'd0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_overflow", 32'(Overflow), 32'd0);
    chk("rst_commits", CommitCount, 32'd0);
    chk("rst_drops", DropCount, 32'd0);
    chk("rst_pc", TracePC, 32'd0);
    chk("rst_dest", 32'(TraceDest), 32'd0);
    chk("rst_data", TraceData, 32'd0);

    exp_cnt = 0;
    exp_commits = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].cap, vecs[i].rw, vecs[i].stl, vecs[i].dest, vecs[i].pc, vecs[i].data,
            1'b0, 1'b0);
      if (vecs[i].stored) begin
        sb.push_back('{vecs[i].pc, vecs[i].dest, vecs[i].data});
        exp_cnt++;
        exp_commits++;
      end
      chk($sformatf("vec%0d_count", i), 32'(Count), 32'(exp_cnt));
      chk($sformatf("vec%0d_commits", i), CommitCount, 32'(exp_commits));
      chk_head($sformatf("vec%0d_head", i));
    end
    drain("table_drain");

    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(Count), 32'd0);
    commit(32'h0000_0100, 5'd7, 32'hCAFE_0001);
    sb.push_back('{32'h0000_0100, 5'd7, 32'hCAFE_0001});
    chk_head("after_empty_pop");
    drain("empty_pop_drain");

    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush1_commits", CommitCount, 32'd0);
    for (int i = 0; i < 18; i++) begin
      commit(32'h0000_1000 + 32'(i * 4), 5'(1 + i), 32'hA000_0000 + 32'(i));
      if (i < DEPTH) sb.push_back('{32'h0000_1000 + 32'(i * 4), 5'(1 + i), 32'hA000_0000 + 32'(i)});
    end
    chk("ovf_full", 32'(Full), 32'd1);
    chk("ovf_count", 32'(Count), 32'd16);
    chk("ovf_drops", DropCount, 32'd2);
    chk("ovf_commits", CommitCount, 32'd18);
    chk("ovf_flag", 32'(Overflow), 32'd1);

    chk_head("full_pushpop_head");
    cycle(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_2000, 32'hBEEF_0009, 1'b1, 1'b0);
    void'(sb.pop_front());
    sb.push_back('{32'h0000_2000, 5'd9, 32'hBEEF_0009});
    chk("full_pushpop_count", 32'(Count), 32'd16);
    chk("full_pushpop_drops", DropCount, 32'd2);
    chk("full_pushpop_commits", CommitCount, 32'd19);
    drain("full_drain");

    commit(32'h0000_3000, 5'd10, 32'h0000_0ABC);
    commit(32'h0000_3000, 5'd10, 32'h0000_0ABC);
    sb.push_back('{32'h0000_3000, 5'd10, 32'h0000_0ABC});
    if (!DEDUP) sb.push_back('{32'h0000_3000, 5'd10, 32'h0000_0ABC});
    chk("dup_count", 32'(Count), DEDUP ? 32'd1 : 32'd2);
    chk("dup_commits", CommitCount, DEDUP ? 32'd20 : 32'd21);
    chk("dup_overflow_sticky", 32'(Overflow), 32'd1);
    chk_head("dup_head");

    cycle(1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_4000, 32'h0000_0111, 1'b1, 1'b1);
    sb.delete();
    chk("flush_count", 32'(Count), 32'd0);
    chk("flush_overflow", 32'(Overflow), 32'd0);
    chk("flush_commits", CommitCount, 32'd0);
    chk("flush_drops", DropCount, 32'd0);
    chk("flush_valid", 32'(TraceValid), 32'd0);
    chk("flush_pc", TracePC, 32'd0);

    commit(32'h0000_5000, 5'd12, 32'h0000_0222);
    commit(32'h0000_5004, 5'd13, 32'h0000_0333);
    chk("pre_rst_count", 32'(Count), 32'd2);
    #2;
    Reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(Count), 32'd0);
    chk("mid_rst_valid", 32'(TraceValid), 32'd0);
    chk("mid_rst_commits", CommitCount, 32'd0);
    chk("mid_rst_data", TraceData, 32'd0);
    Reset = 1'b1;
    commit(32'h0000_6000, 5'd14, 32'h0000_0444);
    sb.push_back('{32'h0000_6000, 5'd14, 32'h0000_0444});
    chk("post_rst_count", 32'(Count), 32'd1);
    chk_head("post_rst_head");
    drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
